// File: rtl/uart_link_checker_pkg.sv
// Shared definitions for the UART link checker: command codes, command table,
// FSM state encoding and LED polarity.
package uart_link_checker_pkg;

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned TIMER_W = 32;
    localparam int unsigned IDX_W   = 2;
    localparam int unsigned RETRY_W = 4;

    localparam logic [DATA_W-1:0] CMD_TURN_ON  = 8'hEE;
    localparam logic [DATA_W-1:0] CMD_TURN_OFF = 8'h55;
    localparam logic [DATA_W-1:0] CMD_TOGGLE   = 8'hC3;

    localparam logic LED_ON  = 1'b0;
    localparam logic LED_OFF = 1'b1;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_SEND,
        ST_WAIT_ECHO,
        ST_GAP,
        ST_FAULT
    } state_t;

    typedef struct packed {
        logic red;
        logic green;
        logic blue;
    } led_t;

    // Command table order: TOGGLE, TURN_ON, TURN_OFF
    function automatic logic [DATA_W-1:0] cmd_lookup(input logic [IDX_W-1:0] idx);
        logic [DATA_W-1:0] cmd;
        case (idx)
            2'd0:    cmd = CMD_TOGGLE;
            2'd1:    cmd = CMD_TURN_ON;
            default: cmd = CMD_TURN_OFF;
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter; done_c is high while the count sits at zero.
module cycle_timer #(
    parameter int unsigned W       = 32,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         done_c
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= RST_VAL;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign done_c = (count == '0);

endmodule

// File: rtl/uart_link_checker.sv
// Periodically sends a command byte to a UART transmitter and checks that the
// same byte comes back on the receiver, with retries, fault latch and stats.
module uart_link_checker
    import uart_link_checker_pkg::*;
#(
    parameter int unsigned INIT_CYCLES    = 24000000,
    parameter int unsigned TIMEOUT_CYCLES = 2400000,
    parameter int unsigned GAP_CYCLES     = 48000000,
    parameter int unsigned MAX_RETRIES    = 3,
    parameter int unsigned NUM_CMDS       = 3,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_fault,
    output logic [7:0]       data_to_tx,
    output logic             start_tx,
    input  logic             tx_busy,
    input  logic [7:0]       data_received,
    input  logic             rx_done,
    input  logic             parity_error,
    output logic             led_red,
    output logic             led_green,
    output logic             led_blue,
    output logic [CNT_W-1:0] pass_count,
    output logic [CNT_W-1:0] fail_count,
    output logic             link_ok
);

    state_t              state, state_nxt;
    logic [IDX_W-1:0]    idx, idx_nxt;
    logic [RETRY_W-1:0]  retry, retry_nxt;
    logic [DATA_W-1:0]   data_nxt;
    logic                start_nxt;
    logic                link_nxt;
    logic [CNT_W-1:0]    pass_nxt, fail_nxt;
    led_t                leds, leds_nxt;

    logic                timer_load_c;
    logic [TIMER_W-1:0]  timer_value_c;
    logic                timer_done_c;
    logic                echo_pass_c;
    logic                echo_fail_c;

    cycle_timer #(
        .W       (TIMER_W),
        .RST_VAL (TIMER_W'(INIT_CYCLES - 1))
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (timer_load_c),
        .value  (timer_value_c),
        .done_c (timer_done_c)
    );

    // Echo verdict; a received byte wins over a coincident timeout
    always_comb begin
        echo_pass_c = 1'b0;
        echo_fail_c = 1'b0;
        if (state == ST_WAIT_ECHO) begin
            if (rx_done) begin
                if (!parity_error && (data_received == data_to_tx)) begin
                    echo_pass_c = 1'b1;
                end else begin
                    echo_fail_c = 1'b1;
                end
            end else if (timer_done_c) begin
                echo_fail_c = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        idx_nxt       = idx;
        retry_nxt     = retry;
        data_nxt      = data_to_tx;
        start_nxt     = 1'b0;
        link_nxt      = link_ok;
        pass_nxt      = pass_count;
        fail_nxt      = fail_count;
        timer_load_c  = 1'b0;
        timer_value_c = '0;

        case (state)
            ST_INIT: begin
                if (timer_done_c) begin
                    state_nxt = ST_SEND;
                    idx_nxt   = '0;
                    retry_nxt = '0;
                end
            end
            ST_SEND: begin
                if (!tx_busy) begin
                    data_nxt      = cmd_lookup(idx);
                    start_nxt     = 1'b1;
                    state_nxt     = ST_WAIT_ECHO;
                    timer_load_c  = 1'b1;
                    timer_value_c = TIMER_W'(TIMEOUT_CYCLES - 1);
                end
            end
            ST_WAIT_ECHO: begin
                if (echo_pass_c) begin
                    if (pass_count != '1) begin
                        pass_nxt = pass_count + CNT_W'(1);
                    end
                    link_nxt      = 1'b1;
                    retry_nxt     = '0;
                    idx_nxt       = (idx == IDX_W'(NUM_CMDS - 1)) ? '0 : idx + IDX_W'(1);
                    state_nxt     = ST_GAP;
                    timer_load_c  = 1'b1;
                    timer_value_c = TIMER_W'(GAP_CYCLES - 1);
                end else if (echo_fail_c) begin
                    if (fail_count != '1) begin
                        fail_nxt = fail_count + CNT_W'(1);
                    end
                    link_nxt = 1'b0;
                    if (retry < RETRY_W'(MAX_RETRIES)) begin
                        retry_nxt = retry + RETRY_W'(1);
                        state_nxt = ST_SEND;
                    end else begin
                        state_nxt = ST_FAULT;
                    end
                end
            end
            ST_GAP: begin
                if (timer_done_c) begin
                    state_nxt = ST_SEND;
                end
            end
            ST_FAULT: begin
                if (clear_fault) begin
                    state_nxt     = ST_GAP;
                    retry_nxt     = '0;
                    timer_load_c  = 1'b1;
                    timer_value_c = TIMER_W'(GAP_CYCLES - 1);
                end
            end
            default: begin
                state_nxt = ST_INIT;
            end
        endcase
    end

    // LEDs follow the current state, so they change one cycle after entry
    always_comb begin
        leds_nxt = '{red: LED_OFF, green: LED_OFF, blue: LED_OFF};
        case (state)
            ST_SEND, ST_WAIT_ECHO: leds_nxt.blue = LED_ON;
            ST_FAULT:              leds_nxt.red  = LED_ON;
            default:               ;
        endcase
        if (link_ok && (state != ST_FAULT) && (state != ST_INIT)) begin
            leds_nxt.green = LED_ON;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_INIT;
            idx        <= '0;
            retry      <= '0;
            data_to_tx <= CMD_TOGGLE;
            start_tx   <= 1'b0;
            link_ok    <= 1'b0;
            pass_count <= '0;
            fail_count <= '0;
            leds       <= '{red: LED_OFF, green: LED_OFF, blue: LED_OFF};
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            retry      <= retry_nxt;
            data_to_tx <= data_nxt;
            start_tx   <= start_nxt;
            link_ok    <= link_nxt;
            pass_count <= pass_nxt;
            fail_count <= fail_nxt;
            leds       <= leds_nxt;
        end
    end

    assign led_red   = leds.red;
    assign led_green = leds.green;
    assign led_blue  = leds.blue;

endmodule

// File: tb/tb_uart_link_checker.sv
// Directed bench for uart_link_checker: loopback, mismatch, coincidence,
// reset, timeout/fault and counter saturation scenarios.
module tb_uart_link_checker;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear_fault;
    logic        tx_busy;
    logic [7:0]  data_received;
    logic        rx_done;
    logic        parity_error;

    logic [7:0]  data_to_tx;
    logic        start_tx;
    logic        led_red, led_green, led_blue;
    logic [15:0] pass_count, fail_count;
    logic        link_ok;

    logic [7:0]  s_data;
    logic        s_start, s_red, s_green, s_blue, s_link;
    logic [1:0]  s_pass, s_fail;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_link_checker #(
        .INIT_CYCLES(10), .TIMEOUT_CYCLES(20), .GAP_CYCLES(5),
        .MAX_RETRIES(2), .NUM_CMDS(3), .CNT_W(16)
    ) dut (
        .clk(clk), .reset(reset), .clear_fault(clear_fault),
        .data_to_tx(data_to_tx), .start_tx(start_tx), .tx_busy(tx_busy),
        .data_received(data_received), .rx_done(rx_done), .parity_error(parity_error),
        .led_red(led_red), .led_green(led_green), .led_blue(led_blue),
        .pass_count(pass_count), .fail_count(fail_count), .link_ok(link_ok)
    );

    // Silent receiver, 2-bit counters: only ever fails
    uart_link_checker #(
        .INIT_CYCLES(10), .TIMEOUT_CYCLES(20), .GAP_CYCLES(5),
        .MAX_RETRIES(2), .NUM_CMDS(3), .CNT_W(2)
    ) dut_sat (
        .clk(clk), .reset(reset), .clear_fault(clear_fault),
        .data_to_tx(s_data), .start_tx(s_start), .tx_busy(1'b0),
        .data_received(8'h00), .rx_done(1'b0), .parity_error(1'b0),
        .led_red(s_red), .led_green(s_green), .led_blue(s_blue),
        .pass_count(s_pass), .fail_count(s_fail), .link_ok(s_link)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_start(output int n);
        n = -1;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            if (start_tx) begin
                n = i;
                return;
            end
        end
    endtask

    task automatic echo(input logic [7:0] b, input int delay, input logic perr);
        repeat (delay) @(negedge clk);
        data_received = b;
        parity_error  = perr;
        rx_done       = 1'b1;
        @(negedge clk);
        rx_done       = 1'b0;
        parity_error  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp_seq [4];
        int         exp_lat [4];
        int         n;
        logic       seen;

        exp_seq = '{8'hC3, 8'hEE, 8'h55, 8'hC3};
        exp_lat = '{11, 1, 4, 5};
        reset = 1'b0; clear_fault = 1'b0; tx_busy = 1'b0;
        data_received = 8'h00; rx_done = 1'b0; parity_error = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_start_tx", 32'(start_tx), 32'd0);
        check("rst_data", 32'(data_to_tx), 32'hC3);
        check("rst_leds", 32'({led_red, led_green, led_blue}), 32'b111);
        check("rst_counts", 32'({pass_count, fail_count}), 32'd0);
        reset = 1'b1;

        // Loopback: three good echoes, then the table wraps
        for (int i = 0; i < 3; i++) begin
            wait_start(n);
            check("lb_latency", 32'(n), 32'(exp_lat[i]));
            check("lb_byte", 32'(data_to_tx), 32'(exp_seq[i]));
            @(negedge clk);
            check("lb_pulse_width", 32'(start_tx), 32'd0);
            check("lb_led_blue", 32'(led_blue), 32'd0);
            echo(data_to_tx, 1, 1'b0);
            check("lb_pass_count", 32'(pass_count), 32'(i + 1));
            check("lb_fail_count", 32'(fail_count), 32'd0);
            check("lb_link_ok", 32'(link_ok), 32'd1);
            @(negedge clk);
            check("lb_led_green", 32'(led_green), 32'd0);
            if (i == 0) begin
                tx_busy = 1'b1;
                seen = 1'b0;
                repeat (12) begin
                    @(negedge clk);
                    if (start_tx) seen = 1'b1;
                end
                check("busy_hold", 32'(seen), 32'd0);
                tx_busy = 1'b0;
            end
            if (i == 1) begin
                echo(8'h12, 0, 1'b0);
                check("gap_rx_ignored", 32'({pass_count, fail_count}), {16'd2, 16'd0});
            end
        end
        wait_start(n);
        check("wrap_latency", 32'(n), 32'(exp_lat[3]));
        check("wrap_byte", 32'(data_to_tx), 32'(exp_seq[3]));

        // Mismatch, then parity error, then a clean echo of the same command
        echo(8'h00, 2, 1'b0);
        check("mm_fail_count", 32'(fail_count), 32'd1);
        check("mm_link_ok", 32'(link_ok), 32'd0);
        check("mm_pass_count", 32'(pass_count), 32'd3);
        wait_start(n);
        check("mm_resend_latency", 32'(n), 32'd1);
        check("mm_resend_byte", 32'(data_to_tx), 32'hC3);
        echo(8'hC3, 2, 1'b1);
        check("par_fail_count", 32'(fail_count), 32'd2);
        wait_start(n);
        check("par_resend_byte", 32'(data_to_tx), 32'hC3);
        echo(8'hC3, 2, 1'b0);
        check("mm_recover_pass", 32'(pass_count), 32'd4);
        check("mm_recover_link", 32'(link_ok), 32'd1);

        // rx_done on the last timeout cycle
        wait_start(n);
        check("co_latency", 32'(n), 32'd6);
        check("co_byte", 32'(data_to_tx), 32'hEE);
        echo(8'hEE, 19, 1'b0);
        check("co_pass_count", 32'(pass_count), 32'd5);
        check("co_fail_count", 32'(fail_count), 32'd2);

        // Reset while waiting for an echo
        wait_start(n);
        check("rs_byte", 32'(data_to_tx), 32'h55);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rs_data", 32'(data_to_tx), 32'hC3);
        check("rs_link_ok", 32'(link_ok), 32'd0);
        check("rs_leds", 32'({led_red, led_green, led_blue}), 32'b111);
        check("rs_counts", 32'({pass_count, fail_count}), 32'd0);
        check("rs_start_tx", 32'(start_tx), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        wait_start(n);
        check("rs_init_latency", 32'(n), 32'd11);
        check("rs_first_byte", 32'(data_to_tx), 32'hC3);

        // Silent receiver: two resends, then FAULT
        for (int i = 0; i < 2; i++) begin
            wait_start(n);
            check("to_resend_spacing", 32'(n), 32'd21);
            check("to_resend_byte", 32'(data_to_tx), 32'hC3);
        end
        repeat (21) @(negedge clk);
        check("to_fail_count", 32'(fail_count), 32'd3);
        check("to_led_red", 32'(led_red), 32'd0);
        check("to_led_blue", 32'(led_blue), 32'd1);
        check("to_link_ok", 32'(link_ok), 32'd0);
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (start_tx) seen = 1'b1;
        end
        check("fault_sticky", 32'(seen), 32'd0);
        check("fault_led_red", 32'(led_red), 32'd0);

        clear_fault = 1'b1;
        @(negedge clk);
        clear_fault = 1'b0;
        wait_start(n);
        check("cf_latency", 32'(n), 32'd6);
        check("cf_byte", 32'(data_to_tx), 32'hC3);
        check("cf_fail_kept", 32'(fail_count), 32'd3);
        check("cf_led_red_off", 32'(led_red), 32'd1);

        // Two more timeouts: 5 fails total
        repeat (42) @(negedge clk);
        check("sat_wide_fail", 32'(fail_count), 32'd5);
        check("sat_narrow_fail", 32'(s_fail), 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
